// File: rtl/onchip_mem_arbiter.sv
// onchip_mem_arbiter
//   Two-master round-robin arbiter in front of a single-port 32-bit on-chip
//   memory with one cycle of read latency. At most one transfer is issued per
//   cycle. The losing master is stalled with waitrequest. Read data is
//   returned to the master that issued the read, qualified by a one-cycle
//   readdatavalid pulse.
//
//   Optional feature, enabled by defining the macro ONCHIP_ARB_RANGE_CHECK_EN:
//   a granted access whose address is >= DEPTH is blocked from the memory and
//   pulses o_range_err. A blocked read still returns readdatavalid with zero
//   data.
//
// Ports
//   i_clk, i_reset              clock, asynchronous active-high reset
//   i_mN_address/byteenable     master N word address and write byte lanes
//   i_mN_read/write/writedata   master N request strobes and write data
//   o_mN_waitrequest            master N request not accepted this cycle
//   o_mN_readdata/readdatavalid master N read return
//   o_mem_*                     memory chip-select/write/address port
//   i_mem_readdata              memory read data, one cycle after address
//   o_range_err                 out-of-range access pulse
module onchip_mem_arbiter #(
  parameter int DEPTH = 51200,
  parameter int AW    = 16
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic [AW-1:0] i_m0_address,
  input  logic [3:0]    i_m0_byteenable,
  input  logic          i_m0_read,
  input  logic          i_m0_write,
  input  logic [31:0]   i_m0_writedata,
  output logic          o_m0_waitrequest,
  output logic [31:0]   o_m0_readdata,
  output logic          o_m0_readdatavalid,
  input  logic [AW-1:0] i_m1_address,
  input  logic [3:0]    i_m1_byteenable,
  input  logic          i_m1_read,
  input  logic          i_m1_write,
  input  logic [31:0]   i_m1_writedata,
  output logic          o_m1_waitrequest,
  output logic [31:0]   o_m1_readdata,
  output logic          o_m1_readdatavalid,
  output logic [AW-1:0] o_mem_address,
  output logic [3:0]    o_mem_byteenable,
  output logic          o_mem_chipselect,
  output logic          o_mem_write,
  output logic [31:0]   o_mem_writedata,
  output logic          o_mem_clken,
  input  logic [31:0]   i_mem_readdata,
  output logic          o_range_err
);

  logic          r_last_grant;
  logic          r_rd_pend;
  logic          r_rd_owner;
  logic          r_rd_zero;

  logic          w_req0;
  logic          w_req1;
  logic          w_grant0;
  logic          w_grant1;
  logic          w_any;
  logic          w_is_write;
  logic          w_oor;
  logic [AW-1:0] w_addr;

  // Requests are masked while reset is held so every output sits at its
  // reset value regardless of what the masters are driving.
  assign w_req0 = !i_reset && (i_m0_read || i_m0_write);
  assign w_req1 = !i_reset && (i_m1_read || i_m1_write);

  // On contention the master that did not win last time is granted.
  assign w_grant0 = w_req0 && (!w_req1 || r_last_grant);
  assign w_grant1 = w_req1 && (!w_req0 || !r_last_grant);
  assign w_any    = w_grant0 || w_grant1;

  // A simultaneous read+write is a write; the read strobe is ignored.
  assign w_is_write = w_grant1 ? i_m1_write : (w_grant0 && i_m0_write);

  // With no grant the memory port shows m0's values; chipselect marks them idle.
  assign w_addr           = w_grant1 ? i_m1_address    : i_m0_address;
  assign o_mem_address    = w_addr;
  assign o_mem_byteenable = w_grant1 ? i_m1_byteenable : i_m0_byteenable;
  assign o_mem_writedata  = w_grant1 ? i_m1_writedata  : i_m0_writedata;
  assign o_mem_clken      = 1'b1;

`ifdef ONCHIP_ARB_RANGE_CHECK_EN
  assign w_oor = w_any && (int'(w_addr) >= DEPTH);
`else
  assign w_oor = 1'b0;
`endif

  assign o_mem_chipselect = w_any && !w_oor;
  assign o_mem_write      = w_is_write && !w_oor;
  assign o_range_err      = w_oor;

  assign o_m0_waitrequest = w_req0 && !w_grant0;
  assign o_m1_waitrequest = w_req1 && !w_grant1;

  // Read data is broadcast to both masters; only readdatavalid tells them apart.
  assign o_m0_readdata      = r_rd_zero ? 32'h0 : i_mem_readdata;
  assign o_m1_readdata      = r_rd_zero ? 32'h0 : i_mem_readdata;
  assign o_m0_readdatavalid = r_rd_pend && !r_rd_owner;
  assign o_m1_readdatavalid = r_rd_pend && r_rd_owner;

  // Round-robin pointer plus the one-deep read return pipeline. Reset clears
  // any pending return so it is never emitted after reset release.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_last_grant <= 1'b1;
      r_rd_pend    <= 1'b0;
      r_rd_owner   <= 1'b0;
      r_rd_zero    <= 1'b0;
    end else begin
      if (w_any) begin
        r_last_grant <= w_grant1;
      end
      r_rd_pend  <= w_any && !w_is_write;
      r_rd_owner <= w_grant1;
      r_rd_zero  <= w_oor;
    end
  end

endmodule

// File: doc/onchip_mem_arbiter.md
# onchip_mem_arbiter

Two-requester round-robin arbiter sharing the single-port 32-bit on-chip memory (51200 words, 16-bit word address, byte enables, 1-cycle read latency) between two Avalon-MM style masters. Sits between the masters and the memory's chip-select/write/address port. Issues at most one transfer per cycle, stalls the loser with waitrequest, and routes read data back to the issuing master with readdatavalid.

## Interface
- DEPTH, 51200, number of valid memory words
- AW, 16, word address width
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- m0_address / m1_address  in  AW  word address
- m0_byteenable / m1_byteenable  in  4  byte lanes for write
- m0_read / m1_read  in  1  read request
- m0_write / m1_write  in  1  write request
- m0_writedata / m1_writedata  in  32  write data
- m0_waitrequest / m1_waitrequest  out  1  request not accepted this cycle
- m0_readdata / m1_readdata  out  32  read data
- m0_readdatavalid / m1_readdatavalid  out  1  readdata valid, one-cycle pulse
- mem_address  out  AW  memory address
- mem_byteenable  out  4  memory byte enables
- mem_chipselect  out  1  memory select
- mem_write  out  1  memory write strobe
- mem_writedata  out  32  memory write data
- mem_clken  out  1  memory clock enable, constant 1
- mem_readdata  in  32  memory read data, valid 1 cycle after address
- range_err  out  1  out-of-range access pulse (see Configuration)

## Operation
- Request of master i: req_i = mi_read | mi_write. read and write together: treated as write; read ignored.
- Arbitration (combinational, same cycle): one requester -> granted; both -> the master not in last_grant; none -> idle.
- last_grant register (1 bit), reset value 1 (m0 wins first contention); updates to the granted index on every grant.
- Granted master: waitrequest=0; mem_* driven from its inputs, mem_chipselect=1, mem_write=its write. Loser: waitrequest=1 while its req is high; must hold request stable.
- Idle cycle: mem_chipselect=0, mem_write=0, mem_address/byteenable/writedata hold m0's values (don't care).
- waitrequest=0 when req_i=0.
- Read pipeline: rd_pend (1 bit) and rd_owner (1 bit) registered at grant of a read. Next cycle: owner's readdatavalid=1, readdata=mem_readdata; other master readdatavalid=0.
- mi_readdata driven from mem_readdata for both masters at all times; only readdatavalid qualifies.
- Back-to-back reads by alternating masters fully pipelined: one read per cycle.

## Timing
- Reset: all waitrequest=0, readdatavalid=0, mem_chipselect=0, mem_write=0, range_err=0, rd_pend=0, last_grant=1.
- Grant decision and mem_* outputs: 0-cycle (combinational from requests and last_grant).
- Read latency: granted at edge N -> readdatavalid high cycle N+1, exactly one cycle.
- Write: committed at the edge where waitrequest=0; no response.
- Reset mid-read: pending readdatavalid is dropped, not emitted after reset release.
- Fairness: with both requesting continuously, grants strictly alternate; a waiting master is granted within 1 cycle.

## Configuration
- ONCHIP_ARB_RANGE_CHECK_EN defined: granted access with address >= DEPTH is blocked: mem_chipselect=0, mem_write=0; range_err pulses for 1 cycle at grant. Out-of-range read still returns readdatavalid one cycle later with readdata forced to 32'h0. Grant and last_grant update as normal.
- Undefined: no check; address passed through; range_err tied 0.

## Test plan
- After reset, m0 read addr 0x0010 (mem holds 0xA5A5_0001) -> m0_waitrequest=0 same cycle, m0_readdatavalid=1 with 0xA5A5_0001 next cycle; m1_readdatavalid stays 0.
- m0 and m1 both write continuously 4 cycles (addr 0x20 / 0x30) -> grants m0,m1,m0,m1; loser waitrequest=1 each cycle; memory holds both last values.
- m1 write byteenable 4'b0010 data 0x1234_5678 to word holding 0xFFFF_FFFF, then read -> 0xFFFF_56FF.
- Alternating reads m0@0x1,m1@0x2,m0@0x3 -> readdatavalid pulses on m0,m1,m0 in consecutive cycles with correct data.
- Reset asserted one cycle after read grant -> no readdatavalid on either master; outputs at reset values.
- With ONCHIP_ARB_RANGE_CHECK_EN: m0 write addr 51200 -> mem_chipselect=0, range_err=1 one cycle, memory unchanged; m0 read addr 0xFFFF -> readdatavalid next cycle with readdata 0.
